// File: rtl/i2c_write_word.sv
// i2c_write_word: I2C write of {addr, pointer, data_hi, data_lo} at 3 PT_CK cycles per SCL bit.
// Optional macro I2C_WRITE_NACK_ABORT_EN: jump to STOP after the first NACKed byte.
module i2c_write_word (
    input  logic        PT_CK,
    input  logic        RESET_N,
    input  logic [7:0]  SLAVE_ADDRESS,
    input  logic [7:0]  POINTER,
    input  logic [15:0] DATA16,
    input  logic        GO,
    input  logic        SDAI,
    output logic        SDAO,
    output logic        SCLO,
    output logic        END_OK,
    output logic        ACK_OK,
    output logic [1:0]  NACK_BYTE,
    output logic [7:0]  ST
);
`ifdef I2C_WRITE_NACK_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif
    typedef enum logic [3:0] {
        IDLE, ARMED, LAUNCH, START, START2, BIT_A, BIT_B, BIT_C, STOP1, STOP2, STOP3
    } state_t;
    state_t      st, st_n;
    logic [31:0] word, word_n;
    logic [3:0]  bit_cnt, bit_n;
    logic [1:0]  byte_cnt, byte_n, nbyte_n;
    logic        nacked, nacked_n, sdao_n, sclo_n, end_n, ack_n;
    logic        last, done;
    assign last = bit_cnt == 4'd8;
    assign done = last && (byte_cnt == 2'd3 || (ABORT && nacked));
    assign ST   = {4'b0, st};
    always_ff @(posedge PT_CK or negedge RESET_N) begin
        if (!RESET_N) begin
            st        <= IDLE;
            word      <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            nacked    <= 1'b0;
            SDAO      <= 1'b1;
            SCLO      <= 1'b1;
            END_OK    <= 1'b1;
            ACK_OK    <= 1'b0;
            NACK_BYTE <= '0;
        end else begin
            st        <= st_n;
            word      <= word_n;
            bit_cnt   <= bit_n;
            byte_cnt  <= byte_n;
            nacked    <= nacked_n;
            SDAO      <= sdao_n;
            SCLO      <= sclo_n;
            END_OK    <= end_n;
            ACK_OK    <= ack_n;
            NACK_BYTE <= nbyte_n;
        end
    end
    always_comb begin
        st_n     = st;
        word_n   = word;
        bit_n    = bit_cnt;
        byte_n   = byte_cnt;
        nacked_n = nacked;
        sdao_n   = SDAO;
        sclo_n   = SCLO;
        end_n    = END_OK;
        ack_n    = ACK_OK;
        nbyte_n  = NACK_BYTE;
        case (st)
            IDLE:   st_n = GO ? ARMED : IDLE;
            ARMED: if (!GO) begin
                st_n     = LAUNCH;
                end_n    = 1'b0;
                ack_n    = 1'b0;
                nbyte_n  = 2'd0;
                nacked_n = 1'b0;
                bit_n    = 4'd0;
                byte_n   = 2'd0;
                word_n   = {SLAVE_ADDRESS[7:1], 1'b0, POINTER, DATA16};
            end
            LAUNCH: begin
                st_n   = START;
                sdao_n = 1'b0;
                sclo_n = 1'b1;
            end
            START: begin
                st_n   = START2;
                sclo_n = 1'b0;
            end
            START2: begin
                st_n   = BIT_A;
                sdao_n = word[31];
            end
            BIT_A: begin
                st_n   = BIT_B;
                sclo_n = 1'b1;
                if (last && SDAI && !nacked) begin
                    nacked_n = 1'b1;
                    nbyte_n  = byte_cnt;
                end
            end
            BIT_B: begin
                st_n   = BIT_C;
                sclo_n = 1'b0;
            end
            // Counters advance here so the next phase A already drives the next bit.
            BIT_C: begin
                bit_n  = last ? 4'd0 : bit_cnt + 4'd1;
                byte_n = (last && !done) ? byte_cnt + 2'd1 : byte_cnt;
                st_n   = done ? STOP1 : BIT_A;
                sdao_n = done ? 1'b0 : (bit_n == 4'd8 || word[~{byte_n, bit_n[2:0]}]);
            end
            STOP1: begin
                st_n   = STOP2;
                sclo_n = 1'b1;
            end
            STOP2: begin
                st_n   = STOP3;
                sdao_n = 1'b1;
            end
            STOP3: begin
                st_n  = IDLE;
                end_n = 1'b1;
                ack_n = !nacked;
            end
            default: st_n = IDLE;
        endcase
    end
endmodule
